// File: rtl/spi_ram_controller_pkg.sv
// Shared constants and types for the SPI serial-SRAM bridge.
package spi_ram_controller_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         FRAME_BITS = 40;
    localparam int         DATA_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        WAIT
    } state_e;

    // The SRAM is byte addressed; CPU word N lives at bytes 2N and 2N+1.
    function automatic logic [15:0] byte_addr(input logic [14:0] word_addr);
        return {word_addr, 1'b0};
    endfunction

endpackage

// File: rtl/spi_ram_controller_spi_shift_engine.sv
// SPI mode-0 shifter: sck divider, 40-bit MSB-first transmit, 16-bit receive window.
import spi_ram_controller_pkg::*;

module spi_shift_engine #(
    parameter int unsigned HALF_PERIOD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic                  miso_i,
    output logic                  sck_o,
    output logic                  mosi_o,
    output logic [DATA_BITS-1:0]  rx_o,
    output logic                  done_o
);

    localparam logic [7:0] DIV_RELOAD = 8'(HALF_PERIOD - 1);
    localparam logic [5:0] LAST_BIT   = 6'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] tx_q;
    logic [DATA_BITS-1:0]  rx_q;
    logic [7:0]            div_q;
    logic [5:0]            bit_q;
    logic                  sck_q;
    logic                  active_q;
    logic                  phase_end;

    assign phase_end = active_q && (div_q == 8'd0);
    // Asserted on the clk that ends the high phase of the final bit.
    assign done_o    = phase_end && sck_q && (bit_q == 6'd0);
    assign sck_o     = sck_q;
    assign mosi_o    = tx_q[FRAME_BITS-1];
    assign rx_o      = rx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q     <= '0;
            rx_q     <= '0;
            div_q    <= 8'd0;
            bit_q    <= 6'd0;
            sck_q    <= 1'b0;
            active_q <= 1'b0;
        end else if (start_i) begin
            tx_q     <= frame_i;
            div_q    <= DIV_RELOAD;
            bit_q    <= LAST_BIT;
            sck_q    <= 1'b0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (div_q != 8'd0) begin
                div_q <= div_q - 8'd1;
            end else begin
                div_q <= DIV_RELOAD;
                sck_q <= !sck_q;
                if (!sck_q) begin
                    rx_q <= {rx_q[DATA_BITS-2:0], miso_i};
                end else begin
                    // Shifting on the falling edge keeps mosi stable while sck is high
                    // and leaves the register all-zero once the frame is out.
                    tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_q == 6'd0) begin
                        active_q <= 1'b0;
                    end else begin
                        bit_q <= bit_q - 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_ram_controller.sv
// CPU I/O-bus to SPI SRAM bridge: one 16-bit word per rd/wr strobe, busy stalls the CPU.
import spi_ram_controller_pkg::*;

// state | meaning
// IDLE  | waiting for rd or wr low; captures request and launches the frame
// SHIFT | 40-bit frame on the wire, cs low, busy high
// DONE  | one clk: release cs and busy, latch read data
// WAIT  | hold until both strobes are released

module spi_ram_controller #(
    parameter int unsigned HALF_PERIOD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        rd,
    input  logic        wr,
    output logic        busy,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        cs
);

    state_e                state_q;
    logic                  cs_q;
    logic                  busy_q;
    logic                  is_read_q;
    logic [15:0]           data_out_q;
    logic                  start;
    logic                  done;
    logic [7:0]            cmd;
    logic [FRAME_BITS-1:0] frame;
    logic [DATA_BITS-1:0]  rx_word;
    logic                  unused_addr_msb;

    assign unused_addr_msb = address[15];
    assign start = (state_q == IDLE) && (!rd || !wr);
    assign cmd   = !wr ? CMD_WRITE : CMD_READ;
    assign frame = {cmd, byte_addr(address[14:0]), (!wr ? data_in : 16'h0000)};

    spi_shift_engine #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_engine (
        .clk    (clk),
        .reset  (reset),
        .start_i(start),
        .frame_i(frame),
        .miso_i (miso),
        .sck_o  (sck),
        .mosi_o (mosi),
        .rx_o   (rx_word),
        .done_o (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            is_read_q  <= 1'b0;
            data_out_q <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cs_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        is_read_q <= wr;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    cs_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (is_read_q) begin
                        data_out_q <= rx_word;
                    end
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (rd && wr) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cs       = cs_q;
    assign busy     = busy_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_spi_ram_controller.sv
// Bench for spi_ram_controller: behavioural SPI SRAM, directed vector table, random traffic, HALF_PERIOD=3 timing.
module tb_spi_ram_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = 16'h0;
    logic [15:0] data_in = 16'h0;
    logic [15:0] data_out;
    logic        rd = 1'b1;
    logic        wr = 1'b1;
    logic        busy, sck, mosi, cs;
    logic        miso = 1'b0;

    logic [15:0] address3 = 16'h0;
    logic [15:0] data_in3 = 16'h0;
    logic [15:0] data_out3;
    logic        rd3 = 1'b1;
    logic        wr3 = 1'b1;
    logic        busy3, sck3, mosi3, cs3;
    logic        miso3 = 1'b0;

    always #5 clk = ~clk;

    spi_ram_controller #(.HALF_PERIOD(1)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in), .data_out(data_out),
        .rd(rd), .wr(wr), .busy(busy), .sck(sck), .mosi(mosi), .miso(miso), .cs(cs)
    );

    spi_ram_controller #(.HALF_PERIOD(3)) dut3 (
        .clk(clk), .reset(reset), .address(address3), .data_in(data_in3), .data_out(data_out3),
        .rd(rd3), .wr(wr3), .busy(busy3), .sck(sck3), .mosi(mosi3), .miso(miso3), .cs(cs3)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural 23LC512 in sequential mode: byte array, big-endian words.
    logic [7:0]  mem [0:65535];
    logic [39:0] mon_frame = '0;
    int          mon_bits = 0;
    int          cs_falls = 0;
    logic        rd_cmd = 1'b0;
    logic [15:0] rd_word = 16'h0;

    always @(negedge cs) begin
        mon_bits  = 0;
        mon_frame = '0;
        rd_cmd    = 1'b0;
        cs_falls++;
    end

    always @(posedge sck) begin
        if (cs === 1'b0) begin
            mon_frame = {mon_frame[38:0], mosi};
            mon_bits++;
            if (mon_bits == 24) begin
                rd_cmd  = (mon_frame[23:16] == 8'h03);
                rd_word = {mem[mon_frame[15:0]], mem[mon_frame[15:0] + 16'd1]};
            end
            if (mon_bits == 40 && mon_frame[39:32] == 8'h02) begin
                mem[mon_frame[31:16]]         = mon_frame[15:8];
                mem[mon_frame[31:16] + 16'd1] = mon_frame[7:0];
            end
        end
    end

    always @(negedge sck) begin
        if (cs === 1'b0 && rd_cmd && mon_bits >= 24 && mon_bits < 40)
            miso = rd_word[39 - mon_bits];
    end

    logic [39:0] mon3 = '0;
    always @(negedge cs3) mon3 = '0;
    always @(posedge sck3) if (cs3 === 1'b0) mon3 = {mon3[38:0], mosi3};

    // mosi may move together with the sck fall, never across a sustained high phase.
    int   mosi_bad = 0;
    logic prev_sck = 1'b0;
    logic prev_mosi = 1'b0;
    always @(negedge clk) begin
        if (sck && prev_sck && mosi !== prev_mosi) mosi_bad++;
        prev_sck  = sck;
        prev_mosi = mosi;
    end

    typedef struct {
        logic        w_b;
        logic        r_b;
        logic [15:0] a;
        logic [15:0] d;
        logic [39:0] frame;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs [7];

    task automatic run_txn(input logic w_b, input logic r_b, input logic [15:0] a, input logic [15:0] d,
                           input logic [39:0] exp_frame, input logic [15:0] exp_dout, input string tag);
        int cyc;
        int cs_err;
        @(negedge clk);
        wr = w_b; rd = r_b; address = a; data_in = d;
        @(negedge clk);
        wr = 1'b1; rd = 1'b1; address = 16'($urandom); data_in = 16'($urandom);
        cyc = 0;
        cs_err = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            cyc++;
            if (cs !== 1'b0) cs_err++;
            @(negedge clk);
        end
        chk($sformatf("%s busy_cycles", tag), cyc, 81);
        chk($sformatf("%s cs_window", tag), cs_err, 0);
        chk($sformatf("%s cs_end", tag), cs, 1'b1);
        chk($sformatf("%s sck_idle", tag), sck, 1'b0);
        chk($sformatf("%s frame", tag), mon_frame, exp_frame);
        chk($sformatf("%s data_out", tag), data_out, exp_dout);
    endtask

    logic [15:0] ref_mem [int];
    logic [15:0] ref_dout;

    initial begin
        int g;
        int falls0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        vecs[0] = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 40'h02_0024_BEEF, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h0012, 16'h1111, 40'h03_0024_0000, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 16'h5A5A, 40'h02_FFFE_5A5A, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b0, 16'h7FFF, 16'h0000, 40'h03_FFFE_0000, 16'h5A5A};
        vecs[4] = '{1'b0, 1'b0, 16'h0005, 16'h1234, 40'h02_000A_1234, 16'h5A5A};
        vecs[5] = '{1'b1, 1'b0, 16'h0005, 16'hFFFF, 40'h03_000A_0000, 16'h1234};
        vecs[6] = '{1'b1, 1'b0, 16'h8005, 16'h0000, 40'h03_000A_0000, 16'h1234};

        #23;
        chk("reset cs", cs, 1'b1);
        chk("reset sck", sck, 1'b0);
        chk("reset mosi", mosi, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset data_out", data_out, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].w_b, vecs[i].r_b, vecs[i].a, vecs[i].d, vecs[i].frame, vecs[i].dout,
                    $sformatf("vec%0d", i));

        // Abort a write to word 0x40 at bit 20.
        @(negedge clk);
        wr = 1'b0; address = 16'h0040; data_in = 16'hDEAD;
        @(negedge clk);
        wr = 1'b1;
        g = 0;
        while (mon_bits < 20 && g < 500) begin
            g++;
            @(negedge clk);
        end
        chk("abort reached bit20", (g < 500), 1'b1);
        reset = 1'b0;
        #1;
        chk("abort cs", cs, 1'b1);
        chk("abort sck", sck, 1'b0);
        chk("abort busy", busy, 1'b0);
        chk("abort data_out", data_out, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset idle busy", busy, 1'b0);
        chk("post_reset idle cs", cs, 1'b1);
        chk("abort no write", {mem[16'h0080], mem[16'h0081]}, 16'h0000);

        // rd held low for 300 clks must produce exactly one transaction.
        falls0 = cs_falls;
        @(negedge clk);
        address = 16'h0012; rd = 1'b0;
        repeat (300) @(negedge clk);
        chk("hold single txn", cs_falls - falls0, 1);
        chk("hold data_out", data_out, 16'hBEEF);
        chk("hold busy low", busy, 1'b0);
        rd = 1'b1;
        run_txn(1'b1, 1'b0, 16'h0012, 16'h0000, 40'h03_0024_0000, 16'hBEEF, "rearm");
        chk("rearm second txn", cs_falls - falls0, 2);

        ref_mem[16'h0012] = 16'hBEEF;
        ref_dout = 16'hBEEF;
        for (int i = 0; i < 16; i++) begin
            int          op;
            logic [15:0] a;
            logic [15:0] d;
            logic [15:0] ba;
            op = $urandom_range(0, 2);
            a  = {1'($urandom), 11'h0, 4'($urandom)} | 16'h0100;
            d  = 16'($urandom);
            ba = 16'(2 * int'(a[14:0]));
            if (op == 1) begin
                ref_dout = ref_mem.exists(int'(a[14:0])) ? ref_mem[int'(a[14:0])] : 16'h0000;
                run_txn(1'b1, 1'b0, a, d, {8'h03, ba, 16'h0000}, ref_dout, $sformatf("rnd%0d rd", i));
            end else begin
                ref_mem[int'(a[14:0])] = d;
                run_txn(1'b0, (op == 2) ? 1'b0 : 1'b1, a, d, {8'h02, ba, d}, ref_dout,
                        $sformatf("rnd%0d wr", i));
            end
        end

        chk("mosi stable while sck high", mosi_bad, 0);

        // HALF_PERIOD=3 instance: frame, sck period and busy length.
        begin
            int cyc;
            int rises;
            int first;
            int second;
            logic prev;
            @(negedge clk);
            wr3 = 1'b0; address3 = 16'hFFFF; data_in3 = 16'hA55A;
            @(negedge clk);
            wr3 = 1'b1; address3 = 16'h0000; data_in3 = 16'h0000;
            cyc = 0; rises = 0; first = -1; second = -1; prev = 1'b0;
            while (busy3 === 1'b1 && cyc < 2000) begin
                if (sck3 && !prev) begin
                    rises++;
                    if (first < 0) first = cyc;
                    else if (second < 0) second = cyc;
                end
                prev = sck3;
                cyc++;
                @(negedge clk);
            end
            chk("hp3 busy_cycles", cyc, 241);
            chk("hp3 sck_period", second - first, 6);
            chk("hp3 sck_rises", rises, 40);
            chk("hp3 frame", mon3, 40'h02_FFFE_A55A);
            chk("hp3 cs_end", cs3, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
